uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Serialises the 8-bit game-state/command bytes produced by the game-state stage onto the UART line toward the host game. Producers push bytes through a valid/ready handshake into a small FIFO. An 8N1 transmitter drains the FIFO and sends the bytes back-to-back, LSB first. It runs entirely in the `uart_clk` domain and sits between the game-state logic and the board's TX pin.

## Interface
- `CLKS_PER_BIT`, default 16: `uart_clk` cycles per UART bit; legal range ≥ 2.
- `FIFO_DEPTH`, default 4: byte-queue entries; power of two, ≥ 2.
- `uart_clk` (in, 1): single clock; all logic on the rising edge.
- `rst` (in, 1): synchronous, active-high reset.
- `data_in` (in, 8): byte to enqueue.
- `data_valid` (in, 1): `data_in` is valid this cycle.
- `data_ready` (out, 1): queue can accept a byte this cycle.
- `tx` (out, 1): serial line, registered, idle high.
- `busy` (out, 1): frame in progress or queue non-empty.
- `fifo_count` (out, $clog2(FIFO_DEPTH)+1): bytes currently queued, excluding the byte in the shifter.

## Operation
- **Push**
  - A push occurs at an edge where `data_valid && data_ready`; `data_in` is written at the tail.
  - `data_ready = !rst && (fifo_count != FIFO_DEPTH)`; it is combinational from registered state only.
  - `data_valid` while `data_ready` is low is ignored; the byte is dropped and no error is flagged.
  - If `data_valid` is held high, one copy is pushed per accepting cycle; producers must pulse it.
- **Transmitter FSM states:** IDLE, START, DATA, STOP. Internal registers are the baud counter (0..CLKS_PER_BIT-1), the bit index (0..7), and an 8-bit shift register.
  - **IDLE:** `tx` = 1. If the FIFO is non-empty, pop the head into the shifter, clear the counters, and go to START.
  - **START:** `tx` = 0 for CLKS_PER_BIT cycles, then DATA.
  - **DATA:** `tx` = shifter[0]. After CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - **STOP:** `tx` = 1 for CLKS_PER_BIT cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Simultaneous push and pop**
  - Both are allowed in one cycle when the FIFO is not full.
  - `fifo_count` is unchanged by that cycle.
  - If the FIFO was empty, the popped byte is not the one being pushed; that byte waits for the next pop. No bypass.
- **FIFO pointers:** head/tail wrap modulo FIFO_DEPTH. Full and empty are distinguished by `fifo_count`, not by pointer equality.
- `busy` = (state != IDLE) || (fifo_count != 0).

## Timing
- **Reset** (`rst` sampled high at an edge): after that edge, `tx`=1, state=IDLE, `fifo_count`=0, `busy`=0, pointers=0 and the shifter=0. `data_ready`=0 while `rst` is high, and 1 on the first cycle after release.
- **Reset mid-frame:** the frame is aborted and `tx` returns high after the reset edge. All queued bytes are discarded, and no partial frame resumes.
- **Latency:** a byte pushed at edge N into an empty, idle block is popped at edge N+1. `tx` falls after edge N+2, because `tx` is registered from the state set at N+1.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles from `tx` falling to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **`fifo_count`:** updates on the edge of each push or pop. It never exceeds FIFO_DEPTH and never underflows.
- **`busy`:** falls on the cycle after the last stop-bit cycle when the queue is empty.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, push 8'h45 once → `tx` high; then low for 4 cycles; then bits 1,0,1,0,0,0,1,0 for 4 cycles each; then high for 4 cycles. `busy` high for the whole frame and low after it; `fifo_count` returns to 0.
- **Back-to-back with overflow:** FIFO_DEPTH=4, push 8'h01..8'h06 on consecutive cycles while the first frame starts.
  - `data_ready` falls after 8'h05 is accepted; 8'h06 is dropped. This holds because 8'h01 was popped at the first pop edge, leaving four queued bytes.
  - Five contiguous frames 01..05 follow with no idle cycle between stop and start.
- **Full-queue ready:** fill 4 bytes while a frame is in progress → `data_ready`=0 and `fifo_count`=4. At the pop at the next frame boundary, `fifo_count`=3 and `data_ready`=1 in the same cycle.
- **Reset mid-frame:** assert `rst` for 1 cycle during DATA bit 3 with 2 bytes queued → `tx`=1 next cycle, `fifo_count`=0, `busy`=0, and no further frames.
- **Held valid:** hold `data_valid` high with 8'hA5 for 3 cycles into an empty queue → 3 frames of 8'hA5 transmitted.
- **Push during final stop cycle:** push 8'h3C on the exact last STOP cycle of a frame with an empty queue → transition to IDLE. 8'h3C is popped on the following cycle and its start bit begins one cycle later than back-to-back timing.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte queue feeding an 8N1 UART transmitter in the uart_clk domain.
// Producers push through valid/ready; frames are sent back-to-back, LSB first.
module uart_tx_queue #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         uart_clk,
    input  logic                         rst,
    input  logic [7:0]                   data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                baud_last;
    logic                fifo_nonempty;

    assign fifo_nonempty = (count_q != '0);
    assign baud_last     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign data_ready    = !rst && (count_q != CNT_W'(FIFO_DEPTH));
    assign push          = data_valid && data_ready;
    assign busy          = (state_q != ST_IDLE) || fifo_nonempty;
    assign tx            = tx_q;
    assign fifo_count    = count_q;

    // Queue storage and pointers; pop reads the pre-push head, so there is no bypass.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = data_in;
        end
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Transmit FSM; tx is registered from the current state, so the line lags state by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[head_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[head_q];
                        bit_d   = '0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge uart_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: cycle-exact tx line, occupancy, ready and busy checks.
module tb_uart_tx_queue;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp;
    int n_err;

    // Expected frames: byte value and the sample index where its start bit appears on tx.
    logic [7:0] exp_b [8];
    int         exp_s [8];
    int         nexp;

    uart_tx_queue #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .uart_clk  (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [7:0] v;
        v = b;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return v[k-1];
    endfunction

    function automatic logic exp_tx(input int t);
        for (int i = 0; i < nexp; i++) begin
            if (t >= exp_s[i] && t < exp_s[i] + 10 * int'(CPB)) begin
                return frame_bit(exp_b[i], (t - exp_s[i]) / int'(CPB));
            end
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        tick();
        tick();
        check("rst_tx",    32'(tx), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(data_ready), 32'd1);
    endtask

    initial begin
        logic seen_low;
        logic seen_busy;
        int   cnt_exp [6];
        n_cmp      = 0;
        n_err      = 0;
        nexp       = 0;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;

        // Single byte 8'h45
        do_reset();
        nexp = 1; exp_b[0] = 8'h45; exp_s[0] = 2;
        data_in = 8'h45; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("single_t0_count", 32'(fifo_count), 32'd1);
        check("single_t0_busy",  32'(busy), 32'd1);
        check("single_t0_tx",    32'(tx), 32'd1);
        for (int t = 1; t <= 42; t++) begin
            tick();
            check("single_tx", 32'(tx), 32'(exp_tx(t)));
            if (t <= 40) check("single_busy", 32'(busy), 32'd1);
            if (t == 1) check("single_pop_count", 32'(fifo_count), 32'd0);
        end
        check("single_end_busy",  32'(busy), 32'd0);
        check("single_end_count", 32'(fifo_count), 32'd0);

        // Back-to-back 01..06 with overflow; also full-queue ready at the frame boundary
        do_reset();
        nexp = 5;
        for (int i = 0; i < 5; i++) begin
            exp_b[i] = 8'(i + 1);
            exp_s[i] = 2 + 40 * i;
        end
        cnt_exp = '{1, 1, 2, 3, 4, 4};
        for (int i = 0; i < 6; i++) begin
            data_in    = 8'(i + 1);
            data_valid = 1'b1;
            check("b2b_ready", 32'(data_ready), (i < 5) ? 32'd1 : 32'd0);
            tick();
            check("b2b_tx",    32'(tx), 32'(exp_tx(i)));
            check("b2b_count", 32'(fifo_count), 32'(cnt_exp[i]));
        end
        data_valid = 1'b0;
        for (int t = 6; t <= 205; t++) begin
            tick();
            check("b2b_tx", 32'(tx), 32'(exp_tx(t)));
            if (t == 40) begin
                check("full_count", 32'(fifo_count), 32'd4);
                check("full_ready", 32'(data_ready), 32'd0);
            end
            if (t == 41) begin
                check("boundary_count", 32'(fifo_count), 32'd3);
                check("boundary_ready", 32'(data_ready), 32'd1);
            end
        end
        check("b2b_end_busy",  32'(busy), 32'd0);
        check("b2b_end_count", 32'(fifo_count), 32'd0);

        // Reset during DATA bit 3 with two bytes queued
        do_reset();
        nexp = 1; exp_b[0] = 8'h96; exp_s[0] = 2;
        for (int t = 0; t <= 2; t++) begin
            data_in    = (t == 0) ? 8'h96 : ((t == 1) ? 8'h77 : 8'h88);
            data_valid = 1'b1;
            tick();
            check("mid_tx", 32'(tx), 32'(exp_tx(t)));
        end
        data_valid = 1'b0;
        check("mid_count", 32'(fifo_count), 32'd2);
        for (int t = 3; t <= 17; t++) begin
            tick();
            check("mid_tx", 32'(tx), 32'(exp_tx(t)));
        end
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(data_ready), 32'd0);
        tick();
        check("mid_rst_tx",    32'(tx), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        rst = 1'b0;
        seen_low  = 1'b0;
        seen_busy = 1'b0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (tx == 1'b0) seen_low = 1'b1;
            if (busy == 1'b1) seen_busy = 1'b1;
        end
        check("post_rst_tx_low", 32'(seen_low), 32'd0);
        check("post_rst_busy",   32'(seen_busy), 32'd0);

        // Held valid for three cycles: three frames of 8'hA5
        do_reset();
        nexp = 3;
        for (int i = 0; i < 3; i++) begin
            exp_b[i] = 8'hA5;
            exp_s[i] = 2 + 40 * i;
        end
        data_in    = 8'hA5;
        data_valid = 1'b1;
        for (int t = 0; t <= 2; t++) begin
            tick();
            check("held_tx", 32'(tx), 32'(exp_tx(t)));
        end
        data_valid = 1'b0;
        check("held_count", 32'(fifo_count), 32'd2);
        for (int t = 3; t <= 125; t++) begin
            tick();
            check("held_tx", 32'(tx), 32'(exp_tx(t)));
        end
        check("held_end_busy", 32'(busy), 32'd0);

        // Push on the final STOP cycle of a frame with an empty queue
        do_reset();
        nexp = 2; exp_b[0] = 8'h11; exp_s[0] = 2; exp_b[1] = 8'h3C; exp_s[1] = 43;
        data_in = 8'h11; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            check("last_stop_tx", 32'(tx), 32'(exp_tx(t)));
        end
        data_in = 8'h3C; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("last_stop_tx",    32'(tx), 32'(exp_tx(41)));
        check("last_stop_count", 32'(fifo_count), 32'd1);
        tick();
        check("last_stop_pop",   32'(fifo_count), 32'd0);
        check("last_stop_gap",   32'(tx), 32'd1);
        for (int t = 43; t <= 86; t++) begin
            tick();
            check("last_stop_tx", 32'(tx), 32'(exp_tx(t)));
        end
        check("last_stop_end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
